// File: rtl/cpu_debug_scan_master_pkg.sv
// Shared types and constants for the virtual-JTAG debug scan master.
// Holds the state encoding, IR codes and the debug view of the FSM.
package cpu_debug_pkg;

    localparam int DR_W_DEFAULT = 38;

    localparam logic [1:0] IR_OCIMEM    = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK     = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    typedef struct packed {
        state_t     state;
        logic [7:0] bit_idx;
        logic       step_start;
        logic       sample_pt;
    } dbg_t;

    // tck only runs while a TAP step is in progress
    function automatic logic is_scanning(input state_t s);
        return (s != ST_IDLE) && (s != ST_RESP);
    endfunction

endpackage

// File: rtl/cpu_debug_scan_master_if.sv
// Command/response handshake plus virtual TAP pins of the debug scan master.
// master = scan master view, slave = host + target view.
interface cpu_debug_scan_master_if #(
    parameter int DR_W = cpu_debug_pkg::DR_W_DEFAULT,
    parameter int IR_W = 2
);
    // cmd and rsp use valid/ready: a transfer happens on the clk edge where
    // valid and ready are both high; a raised valid keeps its payload stable
    // until that edge, and ready seen without valid has no effect.
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_dr;
    logic            cmd_ir_only;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] rsp_ir_out;

    logic            vji_tck;
    logic            vji_tdi;
    logic            vji_tdo;
    logic [IR_W-1:0] vji_ir_in;
    logic [IR_W-1:0] vji_ir_out;
    logic            vji_rti;
    logic            vji_uir;
    logic            vji_cdr;
    logic            vji_sdr;
    logic            vji_udr;

    modport master (
        input  cmd_valid, cmd_ir, cmd_dr, cmd_ir_only, rsp_ready,
        input  vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
        output vji_tck, vji_tdi, vji_ir_in,
        output vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_dr, cmd_ir_only, rsp_ready,
        output vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
        input  vji_tck, vji_tdi, vji_ir_in,
        input  vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
    );

endinterface

// File: rtl/cpu_debug_scan_master_tck_gen.sv
// Phase counter for one TAP step: 2*TCK_HALF clk cycles, low phase first.
// Emits tck plus step-start, sample-point and step-done ticks.
module cpu_debug_tck_gen #(
    parameter int TCK_HALF = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_tck,
    output logic o_fall_tick,
    output logic o_sample_tick,
    output logic o_step_done
);

    localparam int PH_N = 2 * TCK_HALF;
    localparam int PH_W = $clog2(PH_N);

    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(TCK_HALF - 1);
    localparam logic [PH_W-1:0] PH_HIGH   = PH_W'(TCK_HALF);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PH_N - 1);

    logic [PH_W-1:0] r_phase;

    // Held at zero while disabled so every step starts on its low phase
    always_ff @(posedge clk) begin
        if (reset || !i_en) begin
            r_phase <= '0;
        end else if (r_phase == PH_LAST) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign o_tck         = i_en && (r_phase >= PH_HIGH);
    assign o_fall_tick   = i_en && (r_phase == '0);
    assign o_sample_tick = i_en && (r_phase == PH_SAMPLE);
    assign o_step_done   = i_en && (r_phase == PH_LAST);

endmodule

// File: rtl/cpu_debug_scan_master.sv
// Virtual-JTAG scan master: turns one IR/DR command into a UIR/CDR/SDR/UDR
// sequence on the virtual TAP and returns the DR word captured from tdo.
module cpu_debug_scan_master
    import cpu_debug_pkg::*;
#(
    parameter int DR_W     = DR_W_DEFAULT,
    parameter int IR_W     = 2,
    parameter int TCK_HALF = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    cpu_debug_scan_master_if.master bus,
    output dbg_t                    o_dbg
);

    localparam int BC_W = $clog2(DR_W);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DR_W-1:0] r_shreg;
    logic [BC_W-1:0] r_bit_cnt;
    logic [IR_W-1:0] r_ir_in;
    logic [IR_W-1:0] r_ir_out;
    logic            r_ir_only;
    logic            r_tdi;

    logic w_en;
    logic w_tck;
    logic w_fall_tick;
    logic w_sample;
    logic w_step_done;
    logic w_cmd_ready;
    logic w_accept;
    logic w_last_bit;
    logic w_rti;
    logic w_uir;
    logic w_cdr;
    logic w_sdr;
    logic w_udr;
    logic w_rsp_valid;

    assign w_en = is_scanning(r_state);

    cpu_debug_tck_gen #(
        .TCK_HALF (TCK_HALF)
    ) u_tck_gen (
        .clk           (clk),
        .reset         (reset),
        .i_en          (w_en),
        .o_tck         (w_tck),
        .o_fall_tick   (w_fall_tick),
        .o_sample_tick (w_sample),
        .o_step_done   (w_step_done)
    );

    assign w_cmd_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_last_bit  = (r_bit_cnt == BC_W'(DR_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rti       = 1'b0;
        w_uir       = 1'b0;
        w_cdr       = 1'b0;
        w_sdr       = 1'b0;
        w_udr       = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rti = 1'b1;
                if (w_accept) w_state_nxt = ST_UIR;
            end
            ST_UIR: begin
                w_uir = 1'b1;
                if (w_step_done) w_state_nxt = r_ir_only ? ST_RESP : ST_CDR;
            end
            ST_CDR: begin
                w_cdr = 1'b1;
                if (w_step_done) w_state_nxt = ST_SDR;
            end
            ST_SDR: begin
                w_sdr = 1'b1;
                if (w_step_done && w_last_bit) w_state_nxt = ST_UDR;
            end
            ST_UDR: begin
                w_udr = 1'b1;
                if (w_step_done) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_ir_in   <= '0;
            r_ir_out  <= '0;
            r_ir_only <= 1'b0;
            r_tdi     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shreg   <= bus.cmd_dr;
                r_ir_in   <= bus.cmd_ir;
                r_ir_only <= bus.cmd_ir_only;
            end
            if (w_sample && (r_state == ST_UIR)) r_ir_out <= bus.vji_ir_out;
            if (w_sample && (r_state == ST_SDR)) r_shreg <= {bus.vji_tdo, r_shreg[DR_W-1:1]};
            if (w_step_done && (r_state == ST_SDR)) begin
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            end
            // tdi is set at the edge that opens a step, so it is already
            // stable when the target shifts on the rising tck of that step
            if (w_accept || w_step_done) begin
                r_tdi <= (w_state_nxt == ST_SDR) ? r_shreg[0] : 1'b0;
            end
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_dr     = (w_rsp_valid && !r_ir_only) ? r_shreg : '0;
    assign bus.rsp_ir_out = r_ir_out;

    assign bus.vji_tck    = w_tck;
    assign bus.vji_tdi    = r_tdi;
    assign bus.vji_ir_in  = r_ir_in;
    assign bus.vji_rti    = w_rti;
    assign bus.vji_uir    = w_uir;
    assign bus.vji_cdr    = w_cdr;
    assign bus.vji_sdr    = w_sdr;
    assign bus.vji_udr    = w_udr;

    assign o_dbg.state      = r_state;
    assign o_dbg.bit_idx    = 8'(r_bit_cnt);
    assign o_dbg.step_start = w_fall_tick;
    assign o_dbg.sample_pt  = w_sample;

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Bench for cpu_debug_scan_master: loopback target models on two builds
// (TCK_HALF=2 and TCK_HALF=1), directed plus random scans against a model.
module tb_cpu_debug_scan_master;
    import cpu_debug_pkg::*;

    localparam int DR_W = 38;
    localparam int IR_W = 2;
    localparam int H    = 2;
    localparam int H2   = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_debug_scan_master_if #(.DR_W(DR_W), .IR_W(IR_W)) bus ();
    cpu_debug_scan_master_if #(.DR_W(DR_W), .IR_W(IR_W)) bus2 ();
    dbg_t dbg;
    dbg_t dbg2;

    cpu_debug_scan_master #(.DR_W(DR_W), .IR_W(IR_W), .TCK_HALF(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .o_dbg (dbg)
    );

    cpu_debug_scan_master #(.DR_W(DR_W), .IR_W(IR_W), .TCK_HALF(H2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2),
        .o_dbg (dbg2)
    );

    // Loopback targets: DR shifts toward the LSB on each rising tck in SDR
    logic [DR_W-1:0] tgt_sr;
    logic [DR_W-1:0] tgt2_sr;
    logic [DR_W-1:0] tgt_load_val;
    logic            tgt_load = 1'b0;
    logic            tgt_tck_d = 1'b0;
    logic            tgt2_tck_d = 1'b0;
    logic [IR_W-1:0] tgt_ir_out;

    always @(posedge clk) begin
        if (tgt_load) tgt_sr <= tgt_load_val;
        else if (bus.vji_tck && !tgt_tck_d && bus.vji_sdr) tgt_sr <= {bus.vji_tdi, tgt_sr[DR_W-1:1]};
        tgt_tck_d <= bus.vji_tck;
    end

    always @(posedge clk) begin
        if (tgt_load) tgt2_sr <= tgt_load_val;
        else if (bus2.vji_tck && !tgt2_tck_d && bus2.vji_sdr) tgt2_sr <= {bus2.vji_tdi, tgt2_sr[DR_W-1:1]};
        tgt2_tck_d <= bus2.vji_tck;
    end

    assign bus.vji_tdo     = tgt_sr[0];
    assign bus.vji_ir_out  = tgt_ir_out;
    assign bus2.vji_tdo    = tgt2_sr[0];
    assign bus2.vji_ir_out = tgt_ir_out;

    int n_checks = 0;
    int n_fail   = 0;

    int st_cyc, st_uir, st_cdr, st_sdr, st_udr, st_rti, st_overlap, st_rise, st_irbad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DR_W-1:0] rand_dr();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[DR_W-1:0];
    endfunction

    task automatic load_tgt(input logic [DR_W-1:0] v);
        @(negedge clk);
        tgt_load_val = v;
        tgt_load     = 1'b1;
        @(negedge clk);
        tgt_load     = 1'b0;
    endtask

    // Offers a command in IDLE; returns at the negedge of the first cycle after accept
    task automatic start_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr, input logic ir_only);
        @(negedge clk);
        bus.cmd_valid   = 1'b1;
        bus.cmd_ir      = ir;
        bus.cmd_dr      = dr;
        bus.cmd_ir_only = ir_only;
        check("cmd_ready_idle", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Walks cycles 1.. after accept until rsp_valid, gathering TAP activity
    task automatic wait_rsp(input logic [IR_W-1:0] ir);
        logic prev_tck;
        prev_tck = 1'b0;
        st_cyc = 1; st_uir = 0; st_cdr = 0; st_sdr = 0; st_udr = 0;
        st_rti = 0; st_overlap = 0; st_rise = 0; st_irbad = 0;
        while (bus.rsp_valid !== 1'b1 && st_cyc < 1000) begin
            st_uir += int'(bus.vji_uir);
            st_cdr += int'(bus.vji_cdr);
            st_sdr += int'(bus.vji_sdr);
            st_udr += int'(bus.vji_udr);
            st_rti += int'(bus.vji_rti);
            if ($countones({bus.vji_rti, bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr}) > 1) st_overlap++;
            if (bus.vji_uir && bus.vji_ir_in !== ir) st_irbad++;
            if (bus.vji_tck && !prev_tck) st_rise++;
            prev_tck = bus.vji_tck;
            @(negedge clk);
            st_cyc++;
        end
    endtask

    task automatic take_rsp(output logic [DR_W-1:0] got_dr, output logic [IR_W-1:0] got_ir);
        got_dr = bus.rsp_dr;
        got_ir = bus.rsp_ir_out;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", bus.rsp_valid, 0);
        check("cmd_ready_back", bus.cmd_ready, 1);
    endtask

    // Full transaction against the model: loopback returns the preload, target ends with cmd_dr
    task automatic run_scan(input string tn, input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                            input logic ir_only, input logic [DR_W-1:0] pre, input logic [IR_W-1:0] irout);
        int steps;
        logic [DR_W-1:0] got_dr;
        logic [IR_W-1:0] got_ir;
        steps = ir_only ? 1 : DR_W + 3;
        load_tgt(pre);
        tgt_ir_out = irout;
        start_cmd(ir, dr, ir_only);
        wait_rsp(ir);
        check({tn, "_latency"}, st_cyc, 1 + steps * 2 * H);
        check({tn, "_uir_clks"}, st_uir, 2 * H);
        check({tn, "_cdr_clks"}, st_cdr, ir_only ? 0 : 2 * H);
        check({tn, "_sdr_clks"}, st_sdr, ir_only ? 0 : DR_W * 2 * H);
        check({tn, "_udr_clks"}, st_udr, ir_only ? 0 : 2 * H);
        check({tn, "_rti_clks"}, st_rti, 0);
        check({tn, "_overlap"}, st_overlap, 0);
        check({tn, "_tck_rises"}, st_rise, steps);
        check({tn, "_ir_in"}, st_irbad, 0);
        take_rsp(got_dr, got_ir);
        check({tn, "_rsp_dr"}, got_dr, ir_only ? '0 : pre);
        check({tn, "_rsp_ir_out"}, got_ir, irout);
        check({tn, "_tgt_sr"}, tgt_sr, ir_only ? pre : dr);
        check({tn, "_ir_in_held"}, bus.vji_ir_in, ir);
    endtask

    initial begin
        logic [DR_W-1:0] pre;
        logic [DR_W-1:0] dr_a;
        logic [DR_W-1:0] dr_b;
        logic [DR_W-1:0] got_dr;
        logic [IR_W-1:0] got_ir;
        int cyc;

        bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_dr = '0; bus.cmd_ir_only = 1'b0; bus.rsp_ready = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_ir = '0; bus2.cmd_dr = '0; bus2.cmd_ir_only = 1'b0; bus2.rsp_ready = 1'b0;
        tgt_ir_out = '0;
        tgt_load_val = '0;
        reset = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rti", bus.vji_rti, 1);
        check("rst_tck", bus.vji_tck, 0);
        check("rst_tdi", bus.vji_tdi, 0);
        check("rst_ir_in", bus.vji_ir_in, 0);
        check("rst_strobes", {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr}, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_dr", bus.rsp_dr, 0);
        check("rst_rsp_ir_out", bus.rsp_ir_out, 0);
        check("rst_state", dbg.state, ST_IDLE);
        check("rst_state2", dbg2.state, ST_IDLE);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", bus.cmd_ready, 1);

        // Directed loopback scan on the break register
        run_scan("full", IR_BREAK, 38'h15_0F0F_F0F0, 1'b0, 38'h2A_5555_AAAA, 2'b00);

        // IR-only update
        run_scan("iro", IR_TRACECTRL, rand_dr(), 1'b1, rand_dr(), 2'b01);

        // Random commands
        for (int k = 0; k < 4; k++) begin
            run_scan($sformatf("rnd%0d", k), IR_W'($urandom_range(0, 3)), rand_dr(),
                     1'($urandom_range(0, 1)), rand_dr(), IR_W'($urandom_range(0, 3)));
        end

        // Response back-pressure with commands offered meanwhile
        pre  = rand_dr();
        dr_a = rand_dr();
        dr_b = rand_dr();
        load_tgt(pre);
        start_cmd(IR_OCIMEM, dr_a, 1'b0);
        wait_rsp(IR_OCIMEM);
        check("hold_latency", st_cyc, 1 + (DR_W + 3) * 2 * H);
        for (int i = 0; i < 20; i++) begin
            bus.cmd_valid   = i[0];
            bus.cmd_ir      = IR_TRACEMEM;
            bus.cmd_dr      = dr_b;
            bus.cmd_ir_only = 1'b0;
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_dr", bus.rsp_dr, pre);
            check("hold_cmd_ready", bus.cmd_ready, 0);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        check("rel_cmd_ready_1st", bus.cmd_ready, 0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rel_cmd_ready_2nd", bus.cmd_ready, 1);
        check("rel_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_rsp(IR_TRACEMEM);
        check("rel_latency", st_cyc, 1 + (DR_W + 3) * 2 * H);
        check("rel_ir_in", st_irbad, 0);
        take_rsp(got_dr, got_ir);
        check("rel_rsp_dr", got_dr, dr_a);
        check("rel_tgt_sr", tgt_sr, dr_b);

        // Reset during the high phase of SDR bit 17
        load_tgt(rand_dr());
        start_cmd(IR_OCIMEM, rand_dr(), 1'b0);
        repeat ((1 + (2 + 17) * 2 * H + H) - 1) @(negedge clk);
        check("mid_tck_high", bus.vji_tck, 1);
        check("mid_sdr", bus.vji_sdr, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_tck", bus.vji_tck, 0);
        check("abort_sdr", bus.vji_sdr, 0);
        check("abort_rti", bus.vji_rti, 1);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_cmd_ready", bus.cmd_ready, 0);
        check("abort_tdi", bus.vji_tdi, 0);
        check("abort_ir_in", bus.vji_ir_in, 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", bus.cmd_ready, 1);
        run_scan("post_rst", IR_TRACEMEM, rand_dr(), 1'b0, rand_dr(), IR_W'($urandom_range(0, 3)));

        // TCK_HALF=1 build: full loopback
        pre  = rand_dr();
        dr_a = rand_dr();
        load_tgt(pre);
        @(negedge clk);
        bus2.cmd_valid   = 1'b1;
        bus2.cmd_ir      = IR_OCIMEM;
        bus2.cmd_dr      = dr_a;
        bus2.cmd_ir_only = 1'b0;
        check("h1_cmd_ready", bus2.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
        cyc = 1;
        while (bus2.rsp_valid !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("h1_latency", cyc, 1 + (DR_W + 3) * 2 * H2);
        check("h1_rsp_dr", bus2.rsp_dr, pre);
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        bus2.rsp_ready = 1'b0;
        check("h1_rsp_valid_drop", bus2.rsp_valid, 0);
        check("h1_tgt_sr", tgt2_sr, dr_a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_debug_scan_master.md
Name: cpu_debug_scan_master

Overview:
- Host-side initiator for the Nios II virtual-JTAG debug slave: drives the virtual TAP signals (tck, tdi, ir_in, uir/cdr/sdr/udr/rti strobes) and collects tdo.
- Converts one command (IR + 38-bit DR word) into a complete IR-update / capture / shift / update sequence and returns the captured DR word.
- Used for on-chip debug bring-up and in simulation benches, where it stands in for the JTAG hub in front of the debug slave.

Parameters:
- DR_W, 38, DR scan length in bits (matches debug slave sr width).
- IR_W, 2, virtual IR width.
- TCK_HALF, 2, clk cycles per tck half-period; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_ir  in  IR_W  IR value (00 ocimem, 01 tracemem, 10 break, 11 tracectrl).
- cmd_dr  in  DR_W  data shifted into target.
- cmd_ir_only  in  1  perform UIR step only, no DR scan.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_dr  out  DR_W  DR bits captured from tdo (zero for ir_only).
- rsp_ir_out  out  IR_W  vji_ir_out sampled in UIR step.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to target.
- vji_tdo  in  1  serial data from target.
- vji_ir_in  out  IR_W  IR presented to target.
- vji_ir_out  in  IR_W  IR status from target.
- vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual TAP state strobes.

Behaviour:
- Clock/reset: single clock domain (clk); reset is synchronous and active-high, port name reset.
- Reset values: state IDLE, vji_tck 0, vji_tdi 0, vji_ir_in 0, vji_rti 1, other strobes 0, rsp_valid 0, rsp_dr 0, rsp_ir_out 0. cmd_ready is 0 while reset is high and 1 in IDLE otherwise.
- Step timing: every TAP step is one tck period = 2*TCK_HALF clk cycles, low phase first.
  - Strobes, ir_in and tdi change only on the first clk of the low phase.
  - vji_tck rises on the first clk of the high phase.
  - vji_tdo and vji_ir_out are sampled on the last clk of the low phase, i.e. before the rising edge at which the target shifts.
- States: IDLE -> UIR -> CDR -> SDR -> UDR -> RESP -> IDLE.
  - IDLE: rti=1, tck held low. Accepting a command loads shreg=cmd_dr and the IR, then moves to UIR on the next clk.
  - UIR: 1 step; uir=1; vji_ir_in=cmd_ir (held until the next command); samples ir_out. If cmd_ir_only, go to RESP.
  - CDR: 1 step; cdr=1.
  - SDR: exactly DR_W steps; sdr=1; tdi=shreg[0]. At each sample point shreg <= {tdo, shreg[DR_W-1:1]}, so the LSB goes out first and the captured word is LSB-aligned. A bit counter runs 0..DR_W-1 and wraps to 0 on exit.
  - UDR: 1 step; udr=1.
  - RESP: rsp_valid=1, rsp_dr=shreg (zero if ir_only), tck low, strobes 0. Leaves on rsp_valid & rsp_ready; IDLE on the next clk.
- Latency: with the accept cycle at t=0, the first step starts at t=1.
  - Full scan: rsp_valid rises at t = 1 + (DR_W+3)*2*TCK_HALF (defaults: t=165).
  - IR-only: rsp_valid rises at t = 1 + 2*TCK_HALF (t=5).
- cmd_valid outside IDLE is ignored and the command is not consumed. The earliest next accept is the clk after the response handshake.
- rsp_ready asserted before rsp_valid has no effect. rsp_dr and rsp_ir_out are stable while rsp_valid is high.
- Reset mid-scan: the scan is aborted on the next clk. All outputs take their reset values, the partial response is discarded, and tck returns low without completing the pulse.
- TCK_HALF=1: tck toggles every clk and the sample point is the single low-phase clk.

Decomposition:
- Package cpu_debug_pkg: state enum, IR code constants (IR_OCIMEM, IR_TRACEMEM, IR_BREAK, IR_TRACECTRL), DR_W_DEFAULT=38.
- Sub-module cpu_debug_tck_gen: phase counter that produces vji_tck, fall_tick (step start), sample_tick (last low clk) and step_done. It is enabled only outside IDLE/RESP and cleared by reset.
- The top level holds the FSM, shreg and bit counter.

Test Plan:
- Loopback target model (38-bit sr shifting on tck posedge, tdo=sr[0], preloaded 38'h2A_5555_AAAA), cmd_dr=38'h15_0F0F_F0F0, ir=10 -> rsp_dr=38'h2A_5555_AAAA; model sr=38'h15_0F0F_F0F0; rsp_valid at t=165; ir_in=10 during UIR.
- Strobe sequence check -> exactly one 4-clk uir, one cdr, 152 clk of sdr, one udr; rti low for the whole scan; no strobe overlap; 41 tck rising edges.
- cmd_ir_only=1, ir=11, target ir_out=01 -> rsp_ir_out=01, rsp_dr=0, rsp_valid at t=5, no cdr/sdr/udr pulse.
- Hold rsp_ready=0 for 20 clk while pulsing cmd_valid -> rsp_valid and rsp_dr stable, cmd_ready=0, command not consumed; accepted on the 2nd clk after rsp_ready=1.
- Assert reset at bit 17 of SDR -> next clk: tck=0, sdr=0, rti=1, rsp_valid=0. A new scan afterwards returns correct data from a freshly reloaded model.
- TCK_HALF=1 rebuild, full loopback -> correct data with rsp_valid at t=83.
